// File: rtl/tt_mvex_lq_collector.sv
// Load-queue response collector: in-order id allocation, out-of-order response capture, in-order VRF retire.
// Optional same-cycle head bypass is enabled by defining TT_MVEX_LQ_BYPASS_EN.
module tt_mvex_lq_collector #(
    parameter int LQ_DEPTH_LOG2 = 3,
    parameter int VLEN          = 256,
    parameter int VADDR_W       = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_alloc_vld,
    input  logic [VADDR_W-1:0]       i_alloc_vd,
    output logic                     o_alloc_rdy,
    output logic [LQ_DEPTH_LOG2-1:0] o_alloc_id,
    input  logic                     i_mvex_lqvld,
    input  logic [VLEN-1:0]          i_mvex_lqdata,
    input  logic                     i_mvex_lqexc,
    input  logic [LQ_DEPTH_LOG2-1:0] i_mvex_lqid,
    output logic                     o_wb_vld,
    output logic [VADDR_W-1:0]       o_wb_addr,
    output logic [VLEN-1:0]          o_wb_data,
    output logic                     o_wb_exc,
    input  logic                     i_wb_rdy,
    input  logic                     i_flush,
    output logic [LQ_DEPTH_LOG2:0]   o_count,
    output logic                     o_err_spurious
);
    localparam int DEPTH = 1 << LQ_DEPTH_LOG2;
    localparam int PW    = LQ_DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    logic [DEPTH-1:0]         alloc_q, alloc_d, done_q, done_d;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                     err_q, err_d;
    logic [VADDR_W-1:0]       vd_q   [DEPTH];
    logic [VLEN-1:0]          data_q [DEPTH];
    logic [DEPTH-1:0]         exc_q;
    logic [LQ_DEPTH_LOG2-1:0] head_idx_s, tail_idx_s;
    logic                     alloc_fire_s, rsp_ok_s, byp_s, wb_vld_s, pop_fire_s, store_s;
    logic                     unused_wrap_s;

    // Handshake qualification and next-state of occupancy bits, pointers and error pulse.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = 1'b0;

        head_idx_s   = head_q[LQ_DEPTH_LOG2-1:0];
        tail_idx_s   = tail_q[LQ_DEPTH_LOG2-1:0];
        alloc_fire_s = i_alloc_vld & (count_q != DEPTH_C);
        rsp_ok_s     = i_mvex_lqvld & alloc_q[i_mvex_lqid] & ~done_q[i_mvex_lqid];
`ifdef TT_MVEX_LQ_BYPASS_EN
        byp_s        = rsp_ok_s & (i_mvex_lqid == head_idx_s);
`else
        byp_s        = 1'b0;
`endif
        wb_vld_s     = (alloc_q[head_idx_s] & done_q[head_idx_s]) | byp_s;
        pop_fire_s   = wb_vld_s & i_wb_rdy;
        // A bypassed response that retires immediately never needs storage.
        store_s      = rsp_ok_s & ~i_flush & ~(byp_s & i_wb_rdy);

        if (i_flush) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            err_d = i_mvex_lqvld & ~rsp_ok_s;
            if (rsp_ok_s) begin
                done_d[i_mvex_lqid] = 1'b1;
            end else begin
                done_d = done_d;
            end
            if (pop_fire_s) begin
                alloc_d[head_idx_s] = 1'b0;
                done_d[head_idx_s]  = 1'b0;
                head_d              = head_q + ONE_C;
            end else begin
                head_d = head_q;
            end
            if (alloc_fire_s) begin
                alloc_d[tail_idx_s] = 1'b1;
                done_d[tail_idx_s]  = 1'b0;
                tail_d              = tail_q + ONE_C;
            end else begin
                tail_d = tail_q;
            end
            case ({alloc_fire_s, pop_fire_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry payload storage; contents are only observed once the alloc/done bits qualify them.
    always_ff @(posedge i_clk) begin
        if (alloc_fire_s && !i_flush) begin
            vd_q[tail_idx_s] <= i_alloc_vd;
        end
        if (store_s) begin
            data_q[i_mvex_lqid] <= i_mvex_lqdata;
            exc_q[i_mvex_lqid]  <= i_mvex_lqexc;
        end
    end

    assign unused_wrap_s  = head_q[PW-1] ^ tail_q[PW-1];
    assign o_alloc_rdy    = (count_q != DEPTH_C);
    assign o_alloc_id     = tail_idx_s;
    assign o_count        = count_q;
    assign o_err_spurious = err_q;
    assign o_wb_vld       = wb_vld_s;
    assign o_wb_addr      = wb_vld_s ? vd_q[head_idx_s] : {VADDR_W{1'b0}};
`ifdef TT_MVEX_LQ_BYPASS_EN
    assign o_wb_data = byp_s ? i_mvex_lqdata : (wb_vld_s ? data_q[head_idx_s] : {VLEN{1'b0}});
    assign o_wb_exc  = byp_s ? i_mvex_lqexc  : (wb_vld_s & exc_q[head_idx_s]);
`else
    assign o_wb_data = wb_vld_s ? data_q[head_idx_s] : {VLEN{1'b0}};
    assign o_wb_exc  = wb_vld_s & exc_q[head_idx_s];
`endif
endmodule

// File: tb/tb_tt_mvex_lq_collector.sv
// Self-checking bench for tt_mvex_lq_collector (default build): directed scenarios plus
// randomized traffic against a program-order queue model.
module tb_tt_mvex_lq_collector;
    localparam int L = 3;
    localparam int DEPTH = 8;
    localparam int VLEN = 256;
    localparam int VA = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alloc_vld = 1'b0;
    logic [VA-1:0]   alloc_vd = '0;
    logic            alloc_rdy;
    logic [L-1:0]    alloc_id;
    logic            lqvld = 1'b0;
    logic [VLEN-1:0] lqdata = '0;
    logic            lqexc = 1'b0;
    logic [L-1:0]    lqid = '0;
    logic            wb_vld;
    logic [VA-1:0]   wb_addr;
    logic [VLEN-1:0] wb_data;
    logic            wb_exc;
    logic            wb_rdy = 1'b0;
    logic            flush = 1'b0;
    logic [L:0]      count;
    logic            err;

    int n_vec = 0;
    int n_err = 0;

    tt_mvex_lq_collector #(.LQ_DEPTH_LOG2(L), .VLEN(VLEN), .VADDR_W(VA)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_alloc_vld(alloc_vld), .i_alloc_vd(alloc_vd), .o_alloc_rdy(alloc_rdy), .o_alloc_id(alloc_id),
        .i_mvex_lqvld(lqvld), .i_mvex_lqdata(lqdata), .i_mvex_lqexc(lqexc), .i_mvex_lqid(lqid),
        .o_wb_vld(wb_vld), .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_wb_exc(wb_exc),
        .i_wb_rdy(wb_rdy), .i_flush(flush), .o_count(count), .o_err_spurious(err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding ops in program order, oldest first.
    typedef struct {
        int              id;
        logic [VA-1:0]   vd;
        bit              done;
        logic [VLEN-1:0] data;
        bit              exc;
    } ent_t;
    ent_t mq[$];
    int   m_tail = 0;
    bit   m_err = 1'b0;

    function automatic bit e_vld();
        return (mq.size() > 0) && mq[0].done;
    endfunction
    function automatic logic [VA-1:0] e_addr();
        return e_vld() ? mq[0].vd : '0;
    endfunction
    function automatic logic [VLEN-1:0] e_data();
        return e_vld() ? mq[0].data : '0;
    endfunction
    function automatic bit e_exc();
        return e_vld() ? mq[0].exc : 1'b0;
    endfunction

    task automatic tick();
        bit pop, alc;
        int k;
        ent_t e;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_tail = 0;
            m_err  = 1'b0;
        end else begin
            pop   = e_vld() && wb_rdy;
            alc   = alloc_vld && (mq.size() < DEPTH);
            m_err = 1'b0;
            if (lqvld) begin
                k = -1;
                foreach (mq[j]) if (mq[j].id == int'(lqid)) k = j;
                if (k >= 0 && !mq[k].done) begin
                    mq[k].done = 1'b1;
                    mq[k].data = lqdata;
                    mq[k].exc  = lqexc;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (pop) mq.delete(0);
            if (alc) begin
                e.id = m_tail; e.vd = alloc_vd; e.done = 1'b0; e.data = '0; e.exc = 1'b0;
                mq.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic idle();
        alloc_vld = 1'b0; lqvld = 1'b0; flush = 1'b0; lqexc = 1'b0;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); wb_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mq.delete(); m_tail = 0; m_err = 1'b0;
        #1;
        n_vec++; if (count !== 4'd0)   begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (alloc_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %0b want 1", alloc_rdy); end
        n_vec++; if (alloc_id !== 3'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", alloc_id); end
        n_vec++; if (wb_vld !== 1'b0 || wb_addr !== '0 || wb_data !== '0 || wb_exc !== 1'b0 || err !== 1'b0)
            begin n_err++; $display("FAIL reset_wb got vld=%0b addr=%0d exc=%0b err=%0b want all 0", wb_vld, wb_addr, wb_exc, err); end
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) begin
            alloc_vld = 1'b1; alloc_vd = VA'(3 + i);
            n_vec++; if (alloc_id !== L'(i)) begin n_err++; $display("FAIL inorder_id got %0d want %0d", alloc_id, i); end
            tick();
        end
        idle(); wb_rdy = 1'b1;
        n_vec++; if (count !== 4'd3 || wb_vld !== 1'b0) begin n_err++; $display("FAIL inorder_cnt got cnt=%0d vld=%0b want 3/0", count, wb_vld); end
        lqvld = 1'b1; lqid = 3'd2; lqdata = VLEN'(32'hA); tick();
        n_vec++; if (wb_vld !== 1'b0) begin n_err++; $display("FAIL inorder_noretire got %0b want 0", wb_vld); end
        lqid = 3'd0; lqdata = VLEN'(32'hC); tick();
        n_vec++; if (wb_vld !== 1'b1 || wb_addr !== 5'd3 || wb_data !== VLEN'(32'hC))
            begin n_err++; $display("FAIL inorder_wb0 got vld=%0b addr=%0d data=%0h want 1/3/c", wb_vld, wb_addr, wb_data); end
        lqvld = 1'b0; tick();
        n_vec++; if (wb_vld !== 1'b0 || count !== 4'd2) begin n_err++; $display("FAIL inorder_wait got vld=%0b cnt=%0d want 0/2", wb_vld, count); end
        lqvld = 1'b1; lqid = 3'd1; lqdata = VLEN'($urandom); tick();
        lqvld = 1'b0;
        n_vec++; if (wb_vld !== 1'b1 || wb_addr !== 5'd4) begin n_err++; $display("FAIL inorder_wb1 got vld=%0b addr=%0d want 1/4", wb_vld, wb_addr); end
        tick();
        n_vec++; if (wb_vld !== 1'b1 || wb_addr !== 5'd5 || wb_data !== VLEN'(32'hA))
            begin n_err++; $display("FAIL inorder_wb2 got vld=%0b addr=%0d data=%0h want 1/5/a", wb_vld, wb_addr, wb_data); end
        tick();
        n_vec++; if (wb_vld !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL inorder_empty got vld=%0b cnt=%0d want 0/0", wb_vld, count); end
    endtask

    task automatic test_full_wrap();
        do_flush(); wb_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_vld = 1'b1; alloc_vd = VA'(10 + i); tick();
        end
        idle();
        n_vec++; if (alloc_rdy !== 1'b0 || count !== 4'd8) begin n_err++; $display("FAIL full got rdy=%0b cnt=%0d want 0/8", alloc_rdy, count); end
        lqvld = 1'b1; lqid = 3'd0; lqdata = VLEN'($urandom); tick();
        lqvld = 1'b0; alloc_vld = 1'b1; alloc_vd = 5'd31; wb_rdy = 1'b1; tick();
        alloc_vld = 1'b0; wb_rdy = 1'b0;
        n_vec++; if (count !== 4'd7 || alloc_rdy !== 1'b1 || alloc_id !== 3'd0)
            begin n_err++; $display("FAIL full_nobypass got cnt=%0d rdy=%0b id=%0d want 7/1/0", count, alloc_rdy, alloc_id); end
        alloc_vld = 1'b1; tick(); idle();
        n_vec++; if (count !== 4'd8 || int'(count) != mq.size()) begin n_err++; $display("FAIL full_refill got cnt=%0d want 8", count); end
    endtask

    task automatic test_spurious();
        logic [VLEN-1:0] d1;
        do_flush(); wb_rdy = 1'b0;
        alloc_vld = 1'b1; alloc_vd = 5'd7; tick(); tick(); idle();
        lqvld = 1'b1; lqid = 3'd6; lqdata = VLEN'($urandom); tick();
        lqvld = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_unalloc got %0b want 1", err); end
        tick();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL spur_pulse got %0b want 0", err); end
        d1 = {8{$urandom}};
        lqvld = 1'b1; lqid = 3'd0; lqdata = d1; tick();
        n_vec++; if (err !== 1'b0 || wb_data !== d1) begin n_err++; $display("FAIL spur_first got err=%0b data=%0h want 0/%0h", err, wb_data, d1); end
        lqdata = ~d1; tick();
        lqvld = 1'b0;
        n_vec++; if (err !== 1'b1 || wb_data !== d1) begin n_err++; $display("FAIL spur_dup got err=%0b data=%0h want 1/%0h", err, wb_data, d1); end
        lqvld = 1'b1; lqid = 3'd2; alloc_vld = 1'b1; tick(); idle();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL spur_same_cycle got %0b want 1", err); end
    endtask

    task automatic test_hold();
        logic [VLEN-1:0] d;
        do_flush(); wb_rdy = 1'b0;
        alloc_vld = 1'b1; alloc_vd = 5'd9; tick(); idle();
        d = {8{$urandom}};
        lqvld = 1'b1; lqid = 3'd0; lqdata = d; lqexc = 1'b1; tick(); idle();
        lqdata = '0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (wb_vld !== 1'b1 || wb_exc !== 1'b1 || wb_addr !== 5'd9 || wb_data !== d)
                begin n_err++; $display("FAIL hold got vld=%0b exc=%0b addr=%0d want 1/1/9", wb_vld, wb_exc, wb_addr); end
            tick();
        end
        wb_rdy = 1'b1; tick();
        n_vec++; if (wb_vld !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL hold_pop got vld=%0b cnt=%0d want 0/0", wb_vld, count); end
    endtask

    task automatic test_flush();
        do_flush(); wb_rdy = 1'b0;
        alloc_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin alloc_vd = VA'(i); tick(); end
        idle();
        lqvld = 1'b1; lqid = 3'd0; lqdata = VLEN'($urandom); tick();
        lqid = 3'd2; flush = 1'b1; tick();
        idle();
        n_vec++; if (count !== 4'd0 || wb_vld !== 1'b0 || err !== 1'b0)
            begin n_err++; $display("FAIL flush got cnt=%0d vld=%0b err=%0b want 0/0/0", count, wb_vld, err); end
        n_vec++; if (alloc_id !== 3'd0) begin n_err++; $display("FAIL flush_id got %0d want 0", alloc_id); end
        lqvld = 1'b1; lqid = 3'd1; tick(); idle();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL flush_stale got %0b want 1", err); end
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 400; c++) begin
            alloc_vld = ($urandom_range(0, 1) == 1);
            alloc_vd  = VA'($urandom);
            lqvld     = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                lqid = L'(mq[$urandom_range(0, mq.size() - 1)].id);
            else
                lqid = L'($urandom);
            lqdata = {8{$urandom}};
            lqexc  = ($urandom_range(0, 3) == 0);
            wb_rdy = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            tick();
            n_vec++; if (wb_vld !== e_vld() || wb_addr !== e_addr() || wb_data !== e_data() || wb_exc !== e_exc())
                begin n_err++; $display("FAIL rnd_wb cyc %0d got vld=%0b addr=%0d exc=%0b want %0b/%0d/%0b", c, wb_vld, wb_addr, wb_exc, e_vld(), e_addr(), e_exc()); end
            n_vec++; if (int'(count) != mq.size() || alloc_rdy !== (mq.size() < DEPTH) || int'(alloc_id) != m_tail)
                begin n_err++; $display("FAIL rnd_ctl cyc %0d got cnt=%0d rdy=%0b id=%0d want %0d/%0d", c, count, alloc_rdy, alloc_id, mq.size(), m_tail); end
            n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err cyc %0d got %0b want %0b", c, err, m_err); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_flush(); wb_rdy = 1'b0;
        alloc_vld = 1'b1; tick(); tick(); idle();
        lqvld = 1'b1; lqid = 3'd0; lqdata = VLEN'($urandom); tick(); idle();
        @(negedge clk); rst_n = 1'b0; #1;
        n_vec++; if (wb_vld !== 1'b0 || wb_data !== '0 || wb_addr !== '0 || count !== 4'd0 || alloc_rdy !== 1'b1 || alloc_id !== 3'd0)
            begin n_err++; $display("FAIL async_rst got vld=%0b cnt=%0d rdy=%0b id=%0d want 0/0/1/0", wb_vld, count, alloc_rdy, alloc_id); end
        #2 rst_n = 1'b1;
        mq.delete(); m_tail = 0; m_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_spurious();
        test_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
